gpu_frame_sequencer: RTL and testbench

GPU_FRAME_SEQUENCER -- requirements
Module: gpu_frame_sequencer

---
 rtl/gpu_frame_sequencer_if.sv | 42 ++++
 rtl/gpu_frame_sequencer.sv | 125 ++++++++++++
 tb/tb_gpu_frame_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_frame_sequencer_if.sv
// Command, vertex-stream, memory-write, GPU-config and status signals of the frame sequencer.
// master = command/stream source and GPU side; slave = the sequencer itself.
interface gpu_frame_sequencer_if #(
  parameter int M                = 11,
  parameter int N                = 7,
  parameter int VERTEX_MEM_DEPTH = 16384
);
  localparam int W  = M + N;
  localparam int AW = $clog2(VERTEX_MEM_DEPTH);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [31:0]       cmd_count;
  logic [16*W-1:0]   cmd_matrix;
  logic              s_valid;
  logic              s_ready;
  logic [W-1:0]      s_data;
  logic              abort;
  logic [AW-1:0]     mem_wr_addr;
  logic [W-1:0]      mem_wr_data;
  logic              mem_wr_en;
  logic [31:0]       vertex_count;
  logic [16*W-1:0]   transform_matrix;
  logic              start;
  logic              frame_end;
  logic              busy;
  logic              done;
  logic              err;
  logic [15:0]       frame_cnt;

  modport master (
    output cmd_valid, cmd_count, cmd_matrix, s_valid, s_data, abort, frame_end,
    input  cmd_ready, s_ready, mem_wr_addr, mem_wr_data, mem_wr_en,
           vertex_count, transform_matrix, start, busy, done, err, frame_cnt
  );

  modport slave (
    input  cmd_valid, cmd_count, cmd_matrix, s_valid, s_data, abort, frame_end,
    output cmd_ready, s_ready, mem_wr_addr, mem_wr_data, mem_wr_en,
           vertex_count, transform_matrix, start, busy, done, err, frame_cnt
  );
endinterface

// File: rtl/gpu_frame_sequencer.sv
// Frame sequencer: accepts a frame command, loads its vertex words into memory, configures and
// starts the GPU, then waits for end-of-frame. Abort returns to IDLE from any busy state.
module gpu_frame_sequencer #(
  parameter int M                = 11,
  parameter int N                = 7,
  parameter int VERTEX_MEM_DEPTH = 16384
) (
  input  logic                  clk,
  input  logic                  reset,
  gpu_frame_sequencer_if.slave  bus
);
  localparam int W  = M + N;
  localparam int AW = $clog2(VERTEX_MEM_DEPTH);
  localparam int MW = 16 * W;

  typedef enum logic [1:0] {IDLE, LOAD, KICK, RUN} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_out_en;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   r_wr_addr;
  logic [W-1:0]    r_wr_data;
  logic            r_wr_en;
  logic [31:0]     r_vertex_count;
  logic [MW-1:0]   r_stage;
  logic [MW-1:0]   r_matrix;
  logic            r_start;
  logic            r_done;
  logic            r_err;
  logic [15:0]     r_frame_cnt;

  logic            w_cmd_ready;
  logic            w_s_ready;
  logic            w_busy;
  logic            w_cmd_hs;
  logic            w_cmd_ok;
  logic            w_wr_hs;
  logic            w_last;
  logic            w_frame_done;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_cmd_hs && w_cmd_ok) w_next = LOAD;
      LOAD: begin
        if (bus.abort)             w_next = IDLE;
        else if (w_wr_hs && w_last) w_next = KICK;
      end
      KICK: w_next = bus.abort ? IDLE : RUN;
      RUN: begin
        // r_start marks the start cycle, where frame_end is not yet meaningful
        if (bus.abort)                     w_next = IDLE;
        else if (bus.frame_end && !r_start) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_cmd_ready  = (r_state == IDLE) && r_out_en;
    w_s_ready    = (r_state == LOAD);
    w_busy       = (r_state != IDLE);
    w_cmd_hs     = bus.cmd_valid && w_cmd_ready;
    w_cmd_ok     = (bus.cmd_count != 32'd0) && (bus.cmd_count <= 32'(VERTEX_MEM_DEPTH));
    w_wr_hs      = w_s_ready && bus.s_valid && !bus.abort;
    w_last       = (32'(r_idx) + 32'd1) == r_vertex_count;
    w_frame_done = (r_state == RUN) && bus.frame_end && !r_start && !bus.abort;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_en       <= 1'b0;
      r_idx          <= '0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
      r_wr_en        <= 1'b0;
      r_vertex_count <= '0;
      r_stage        <= '0;
      r_matrix       <= '0;
      r_start        <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_frame_cnt    <= '0;
    end else begin
      r_out_en <= 1'b1;
      r_wr_en  <= w_wr_hs;
      if (w_wr_hs) begin
        r_wr_addr <= r_idx;
        r_wr_data <= bus.s_data;
        r_idx     <= r_idx + AW'(1);
      end
      if (w_cmd_hs) begin
        r_err <= !w_cmd_ok;
        if (w_cmd_ok) begin
          r_vertex_count <= bus.cmd_count;
          r_stage        <= bus.cmd_matrix;
          r_idx          <= '0;
        end
      end
      if (w_wr_hs && w_last) r_matrix <= r_stage;
      r_start <= (r_state == KICK) && !bus.abort;
      r_done  <= (w_cmd_hs && !w_cmd_ok) || w_frame_done;
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign bus.cmd_ready        = w_cmd_ready;
  assign bus.s_ready          = w_s_ready;
  assign bus.busy             = w_busy;
  assign bus.mem_wr_addr      = r_wr_addr;
  assign bus.mem_wr_data      = r_wr_data;
  assign bus.mem_wr_en        = r_wr_en;
  assign bus.vertex_count     = r_vertex_count;
  assign bus.transform_matrix = r_matrix;
  assign bus.start            = r_start;
  assign bus.done             = r_done;
  assign bus.err              = r_err;
  assign bus.frame_cnt        = r_frame_cnt;
endmodule

// File: tb/tb_gpu_frame_sequencer.sv
// Directed bench for gpu_frame_sequencer: per-scenario tasks with inline comparisons.
module tb_gpu_frame_sequencer;
  localparam int M     = 11;
  localparam int N     = 7;
  localparam int DEPTH = 16384;
  localparam int W     = M + N;
  localparam int AW    = 14;
  localparam int MW    = 16 * W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gpu_frame_sequencer_if #(.M(M), .N(N), .VERTEX_MEM_DEPTH(DEPTH)) bus ();
  gpu_frame_sequencer #(.M(M), .N(N), .VERTEX_MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [15:0]   exp_fc = 16'd0;
  logic [MW-1:0] mat_a  = {8{18'h2A5C3, 18'h01F0E}};
  logic [MW-1:0] mat_b  = {16{18'h3FFF1}};

  logic [AW-1:0] wr_addr_q[$];
  logic [W-1:0]  wr_data_q[$];
  int            wr_cyc_q[$];
  int            start_q[$];
  int            done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.mem_wr_en) begin
      wr_addr_q.push_back(bus.mem_wr_addr);
      wr_data_q.push_back(bus.mem_wr_data);
      wr_cyc_q.push_back(cyc);
    end
    if (bus.start) start_q.push_back(cyc);
    if (bus.done)  done_q.push_back(cyc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    start_q.delete(); done_q.delete();
  endtask

  task automatic send_cmd(input logic [31:0] cnt, input logic [MW-1:0] mat);
    bus.cmd_valid = 1'b1; bus.cmd_count = cnt; bus.cmd_matrix = mat;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.cmd_valid = 0; bus.cmd_count = 0; bus.cmd_matrix = '0;
    bus.s_valid = 0; bus.s_data = '0; bus.abort = 0; bus.frame_end = 0;
    repeat (3) step();
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b want 0", bus.cmd_ready); end
    checks++; if ({bus.busy, bus.done, bus.err, bus.start, bus.mem_wr_en, bus.s_ready} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000", {bus.busy, bus.done, bus.err, bus.start, bus.mem_wr_en, bus.s_ready}); end
    checks++; if ({bus.vertex_count, bus.frame_cnt, bus.mem_wr_addr, bus.mem_wr_data} !== '0) begin
      errors++; $display("FAIL reset_regs: vc=%0h fc=%0h addr=%0h data=%0h want 0", bus.vertex_count, bus.frame_cnt, bus.mem_wr_addr, bus.mem_wr_data); end
    checks++; if (bus.transform_matrix !== '0) begin errors++; $display("FAIL reset_matrix: got %0h want 0", bus.transform_matrix); end
    reset = 1'b0;
    step();
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_cmd_ready: got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_frame_end_ignore();
    clear_logs();
    send_cmd(32'd1, mat_b);
    bus.s_valid = 1; bus.s_data = 18'h12345;
    step();
    bus.s_valid = 0;
    checks++; if (bus.transform_matrix !== mat_b) begin errors++; $display("FAIL fe_kick_matrix: got %0h want %0h", bus.transform_matrix, mat_b); end
    step();
    checks++; if (bus.start !== 1'b1) begin errors++; $display("FAIL fe_start: got %b want 1", bus.start); end
    bus.frame_end = 1;
    step();
    bus.frame_end = 0;
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.frame_cnt !== 16'd0) begin
      errors++; $display("FAIL fe_ignored_in_start: busy=%b done=%b fc=%0d want busy=1 done=0 fc=0", bus.busy, bus.done, bus.frame_cnt); end
    repeat (4) step();
    bus.frame_end = 1;
    step();
    bus.frame_end = 0;
    exp_fc = exp_fc + 16'd1;
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.frame_cnt !== exp_fc) begin
      errors++; $display("FAIL fe_end: done=%b busy=%b fc=%0d want done=1 busy=0 fc=%0d", bus.done, bus.busy, bus.frame_cnt, exp_fc); end
    step();
    checks++; if (bus.done !== 1'b0 || start_q.size() != 1) begin
      errors++; $display("FAIL fe_done_pulse: done=%b starts=%0d want done=0 starts=1", bus.done, start_q.size()); end
  endtask

  task automatic test_basic();
    logic [W-1:0] words [3];
    words = '{18'h00A11, 18'h3B0B2, 18'h1CCC3};
    clear_logs();
    send_cmd(32'd3, mat_a);
    checks++; if (bus.s_ready !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1 || bus.vertex_count !== 32'd3) begin
      errors++; $display("FAIL basic_load: s_ready=%b cmd_ready=%b busy=%b vc=%0d want 1 0 1 3", bus.s_ready, bus.cmd_ready, bus.busy, bus.vertex_count); end
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1; bus.s_data = words[i];
      step();
    end
    bus.s_valid = 0;
    checks++; if (bus.transform_matrix !== mat_a || bus.s_ready !== 1'b0) begin
      errors++; $display("FAIL basic_kick: matrix=%0h s_ready=%b want %0h 0", bus.transform_matrix, bus.s_ready, mat_a); end
    step();
    step();
    checks++; if (wr_addr_q.size() != 3 || start_q.size() != 1) begin
      errors++; $display("FAIL basic_counts: writes=%0d starts=%0d want 3 1", wr_addr_q.size(), start_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== words[i]) begin
          errors++; $display("FAIL basic_write%0d: addr=%0d data=%0h want %0d %0h", i, wr_addr_q[i], wr_data_q[i], i, words[i]); end
      end
      checks++; if (wr_cyc_q[2] - wr_cyc_q[0] != 2 || start_q[0] != wr_cyc_q[2] + 1) begin
        errors++; $display("FAIL basic_timing: w0=%0d w2=%0d start=%0d want consecutive, start=w2+1", wr_cyc_q[0], wr_cyc_q[2], start_q[0]); end
    end
    checks++; if (bus.transform_matrix !== mat_a || bus.vertex_count !== 32'd3 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL basic_run_stable: vc=%0d busy=%b matrix=%0h", bus.vertex_count, bus.busy, bus.transform_matrix); end
    bus.frame_end = 1;
    step();
    bus.frame_end = 0;
    exp_fc = exp_fc + 16'd1;
    checks++; if (bus.done !== 1'b1 || bus.frame_cnt !== exp_fc) begin
      errors++; $display("FAIL basic_end: done=%b fc=%0d want 1 %0d", bus.done, bus.frame_cnt, exp_fc); end
    step();
  endtask

  task automatic test_bad_count();
    logic [31:0] bad [2];
    bad = '{32'd0, 32'd16385};
    clear_logs();
    for (int i = 0; i < 2; i++) begin
      send_cmd(bad[i], mat_b);
      checks++; if (bus.err !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
        errors++; $display("FAIL bad_count_%0d: err=%b done=%b busy=%b rdy=%b want 1 1 0 1", bad[i], bus.err, bus.done, bus.busy, bus.cmd_ready); end
      step();
      checks++; if (bus.done !== 1'b0 || bus.err !== 1'b1) begin
        errors++; $display("FAIL bad_pulse_%0d: done=%b err=%b want 0 1", bad[i], bus.done, bus.err); end
    end
    checks++; if (wr_addr_q.size() != 0 || start_q.size() != 0 || bus.vertex_count !== 32'd3 || bus.transform_matrix !== mat_a) begin
      errors++; $display("FAIL bad_side_effects: writes=%0d starts=%0d vc=%0d", wr_addr_q.size(), start_q.size(), bus.vertex_count); end
  endtask

  task automatic test_full_depth();
    int sent = 0;
    int k = 0;
    int bad_words = 0;
    clear_logs();
    send_cmd(32'd16384, mat_a);
    checks++; if (bus.err !== 1'b0 || bus.s_ready !== 1'b1) begin
      errors++; $display("FAIL full_accept: err=%b s_ready=%b want 0 1", bus.err, bus.s_ready); end
    while (sent < DEPTH && k < 40000) begin
      bus.s_valid = (k % 4 != 3);
      bus.s_data  = W'(sent * 5 + 3);
      step();
      if (bus.s_valid) sent++;
      k++;
    end
    bus.s_valid = 0;
    checks++; if (sent != DEPTH) begin errors++; $display("FAIL full_stream_timeout: sent=%0d want %0d", sent, DEPTH); end
    repeat (3) step();
    checks++; if (wr_addr_q.size() != DEPTH || start_q.size() != 1) begin
      errors++; $display("FAIL full_counts: writes=%0d starts=%0d want %0d 1", wr_addr_q.size(), start_q.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== W'(i * 5 + 3)) bad_words++;
      checks++; if (bad_words != 0) begin errors++; $display("FAIL full_addr_seq: bad=%0d want 0", bad_words); end
      checks++; if (start_q[0] != wr_cyc_q[DEPTH-1] + 1 || wr_addr_q[DEPTH-1] !== 14'd16383) begin
        errors++; $display("FAIL full_start: start=%0d last_wr=%0d want last_wr+1", start_q[0], wr_cyc_q[DEPTH-1]); end
    end
    bus.frame_end = 1;
    step();
    bus.frame_end = 0;
    exp_fc = exp_fc + 16'd1;
    checks++; if (bus.done !== 1'b1 || bus.frame_cnt !== exp_fc) begin
      errors++; $display("FAIL full_end: done=%b fc=%0d want 1 %0d", bus.done, bus.frame_cnt, exp_fc); end
    step();
  endtask

  task automatic test_abort();
    clear_logs();
    send_cmd(32'd2, mat_b);
    bus.s_valid = 1; bus.s_data = 18'h00001; step();
    bus.s_data = 18'h00002; step();
    bus.s_valid = 0;
    repeat (3) step();
    bus.frame_end = 1; bus.abort = 1;
    step();
    bus.frame_end = 0; bus.abort = 0;
    checks++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || bus.frame_cnt !== exp_fc) begin
      errors++; $display("FAIL abort_run: busy=%b rdy=%b done=%b fc=%0d want 0 1 0 %0d", bus.busy, bus.cmd_ready, bus.done, bus.frame_cnt, exp_fc); end
    step();
    checks++; if (done_q.size() != 0) begin errors++; $display("FAIL abort_no_done: dones=%0d want 0", done_q.size()); end
    clear_logs();
    send_cmd(32'd4, mat_a);
    bus.s_valid = 1; bus.s_data = 18'h0AAAA; step();
    bus.s_data = 18'h0BBBB; bus.abort = 1; step();
    bus.abort = 0; bus.s_valid = 0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_load_state: busy=%b want 0", bus.busy); end
    repeat (3) step();
    checks++; if (wr_addr_q.size() != 1 || start_q.size() != 0) begin
      errors++; $display("FAIL abort_load_writes: writes=%0d starts=%0d want 1 0", wr_addr_q.size(), start_q.size()); end
    clear_logs();
    send_cmd(32'd1, mat_a);
    bus.s_valid = 1; bus.s_data = 18'h0CCCC; step();
    bus.s_valid = 0;
    step();
    checks++; if (bus.start !== 1'b1) begin errors++; $display("FAIL abort_next_start: got %b want 1", bus.start); end
    step();
    bus.frame_end = 1; step(); bus.frame_end = 0;
    exp_fc = exp_fc + 16'd1;
    checks++; if (bus.done !== 1'b1 || bus.frame_cnt !== exp_fc) begin
      errors++; $display("FAIL abort_next_end: done=%b fc=%0d want 1 %0d", bus.done, bus.frame_cnt, exp_fc); end
    step();
  endtask

  task automatic test_reset_mid_load();
    clear_logs();
    send_cmd(32'd4, mat_b);
    bus.s_valid = 1; bus.s_data = 18'h11111; step();
    bus.s_data = 18'h22222; step();
    reset = 1;
    step();
    checks++; if ({bus.busy, bus.done, bus.err, bus.start, bus.mem_wr_en, bus.s_ready, bus.cmd_ready} !== 7'b0) begin
      errors++; $display("FAIL rst_load_flags: got %b want 0000000", {bus.busy, bus.done, bus.err, bus.start, bus.mem_wr_en, bus.s_ready, bus.cmd_ready}); end
    checks++; if ({bus.vertex_count, bus.frame_cnt, bus.mem_wr_addr, bus.mem_wr_data} !== '0 || bus.transform_matrix !== '0) begin
      errors++; $display("FAIL rst_load_regs: vc=%0d fc=%0d addr=%0h matrix=%0h want 0", bus.vertex_count, bus.frame_cnt, bus.mem_wr_addr, bus.transform_matrix); end
    clear_logs();
    step();
    reset = 0; bus.s_valid = 0;
    repeat (6) step();
    checks++; if (wr_addr_q.size() != 0 || start_q.size() != 0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_load_after: writes=%0d starts=%0d rdy=%b want 0 0 1", wr_addr_q.size(), start_q.size(), bus.cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_frame_end_ignore();
    test_basic();
    test_bad_count();
    test_full_depth();
    test_abort();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
